// File: rtl/pipe_mem_rd_arbiter.sv
// Single-outstanding read-port arbiter between instruction fetch and loads.
// Loads have fixed priority; a flushed fetch response is drained and dropped.
module pipe_mem_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [ADDR_WIDTH-1:0] ifu_araddr_i,
  input  logic                  ifu_arvalid_i,
  output logic                  ifu_arready_o,
  output logic [DATA_WIDTH-1:0] ifu_rdata_o,
  output logic                  ifu_rvalid_o,
  input  logic                  ifu_rready_i,
  input  logic [ADDR_WIDTH-1:0] lsu_araddr_i,
  input  logic                  lsu_arvalid_i,
  output logic                  lsu_arready_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  lsu_rvalid_o,
  input  logic                  lsu_rready_i,
  output logic [ADDR_WIDTH-1:0] mem_araddr_o,
  output logic                  mem_arvalid_o,
  input  logic                  mem_arready_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_rvalid_i,
  output logic                  mem_rready_o
);

  typedef enum logic [2:0] {
    IDLE,
    IFU_AR,
    IFU_R,
    LSU_AR,
    LSU_R,
    DRAIN
  } state_e;

  state_e state_q, state_d;
  logic   drop_q, drop_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  // Read data is shared; only the valid strobes select the receiving master.
  assign ifu_rdata_o = mem_rdata_i;
  assign lsu_rdata_o = mem_rdata_i;

  always_comb begin
    state_d       = state_q;
    drop_d        = drop_q;
    mem_araddr_o  = '0;
    mem_arvalid_o = 1'b0;
    mem_rready_o  = 1'b0;
    ifu_arready_o = 1'b0;
    ifu_rvalid_o  = 1'b0;
    lsu_arready_o = 1'b0;
    lsu_rvalid_o  = 1'b0;

    case (state_q)
      IDLE: begin
        if (lsu_arvalid_i) begin
          state_d = LSU_AR;
        end else if (ifu_arvalid_i) begin
          state_d = IFU_AR;
        end
      end

      // A flush during the fetch address phase cannot retract the request,
      // so remember it and send the response to DRAIN instead.
      IFU_AR: begin
        mem_araddr_o  = ifu_araddr_i;
        mem_arvalid_o = ifu_arvalid_i;
        ifu_arready_o = mem_arready_i;
        if (flush_i) begin
          drop_d = 1'b1;
        end
        if (ifu_arvalid_i && mem_arready_i) begin
          state_d = (drop_q || flush_i) ? DRAIN : IFU_R;
        end
      end

      IFU_R: begin
        if (flush_i) begin
          state_d = DRAIN;
        end else begin
          ifu_rvalid_o = mem_rvalid_i;
          mem_rready_o = ifu_rready_i;
          if (mem_rvalid_i && ifu_rready_i) begin
            state_d = IDLE;
          end
        end
      end

      LSU_AR: begin
        mem_araddr_o  = lsu_araddr_i;
        mem_arvalid_o = lsu_arvalid_i;
        lsu_arready_o = mem_arready_i;
        if (lsu_arvalid_i && mem_arready_i) begin
          state_d = LSU_R;
        end
      end

      LSU_R: begin
        lsu_rvalid_o = mem_rvalid_i;
        mem_rready_o = lsu_rready_i;
        if (mem_rvalid_i && lsu_rready_i) begin
          state_d = IDLE;
        end
      end

      DRAIN: begin
        mem_rready_o = 1'b1;
        if (mem_rvalid_i) begin
          state_d = IDLE;
          drop_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        drop_d  = 1'b0;
      end
    endcase

    // Keep every handshake output quiet while reset is held.
    if (rst_i) begin
      mem_araddr_o  = '0;
      mem_arvalid_o = 1'b0;
      mem_rready_o  = 1'b0;
      ifu_arready_o = 1'b0;
      ifu_rvalid_o  = 1'b0;
      lsu_arready_o = 1'b0;
      lsu_rvalid_o  = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_mem_rd_arbiter.sv
// Bench for pipe_mem_rd_arbiter: directed cycle vectors, a transaction-level
// ownership model checked every cycle, and hand-computed spot checks.
module tb_pipe_mem_rd_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic [AW-1:0] ifuAraddr = '0;
  logic          ifuArvalid = 1'b0;
  logic          ifuArready;
  logic [DW-1:0] ifuRdata;
  logic          ifuRvalid;
  logic          ifuRready = 1'b0;
  logic [AW-1:0] lsuAraddr = '0;
  logic          lsuArvalid = 1'b0;
  logic          lsuArready;
  logic [DW-1:0] lsuRdata;
  logic          lsuRvalid;
  logic          lsuRready = 1'b0;
  logic [AW-1:0] memAraddr;
  logic          memArvalid;
  logic          memArready = 1'b0;
  logic [DW-1:0] memRdata = '0;
  logic          memRvalid = 1'b0;
  logic          memRready;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  pipe_mem_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i(clock), .rst_i(reset), .flush_i(flush),
    .ifu_araddr_i(ifuAraddr), .ifu_arvalid_i(ifuArvalid), .ifu_arready_o(ifuArready),
    .ifu_rdata_o(ifuRdata), .ifu_rvalid_o(ifuRvalid), .ifu_rready_i(ifuRready),
    .lsu_araddr_i(lsuAraddr), .lsu_arvalid_i(lsuArvalid), .lsu_arready_o(lsuArready),
    .lsu_rdata_o(lsuRdata), .lsu_rvalid_o(lsuRvalid), .lsu_rready_i(lsuRready),
    .mem_araddr_o(memAraddr), .mem_arvalid_o(memArvalid), .mem_arready_i(memArready),
    .mem_rdata_i(memRdata), .mem_rvalid_i(memRvalid), .mem_rready_o(memRready)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // One cycle's input vector, applied just after the rising edge.
  task automatic applyStimulus(input logic ifuV, input logic [31:0] ifuA, input logic ifuRr,
                               input logic lsuV, input logic [31:0] lsuA, input logic lsuRr,
                               input logic memArr, input logic memRv, input logic [31:0] memRd,
                               input logic fl);
    @(posedge clock);
    #1;
    ifuArvalid = ifuV;  ifuAraddr = ifuA;  ifuRready = ifuRr;
    lsuArvalid = lsuV;  lsuAraddr = lsuA;  lsuRready = lsuRr;
    memArready = memArr; memRvalid = memRv; memRdata = memRd;
    flush = fl;
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Transaction model: who owns the port (0 none, 1 fetch, 2 load, 3 discard),
  // whether its address has been accepted, and whether the fetch was killed.
  int owner       = 0;
  bit addrDone    = 1'b0;
  bit dropPending = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      owner       <= 0;
      addrDone    <= 1'b0;
      dropPending <= 1'b0;
    end else begin
      case (owner)
        0: begin
          if (lsuArvalid) begin
            owner <= 2; addrDone <= 1'b0;
          end else if (ifuArvalid) begin
            owner <= 1; addrDone <= 1'b0;
          end
        end
        1: begin
          if (!addrDone) begin
            if (flush) dropPending <= 1'b1;
            if (ifuArvalid && memArready) begin
              if (dropPending || flush) owner <= 3;
              else addrDone <= 1'b1;
            end
          end else if (flush) begin
            owner <= 3;
          end else if (memRvalid && ifuRready) begin
            owner <= 0;
          end
        end
        2: begin
          if (!addrDone) begin
            if (lsuArvalid && memArready) addrDone <= 1'b1;
          end else if (memRvalid && lsuRready) begin
            owner <= 0;
          end
        end
        default: begin
          if (memRvalid) begin
            owner <= 0; dropPending <= 1'b0;
          end
        end
      endcase
    end
  end

  logic          ifuAddrPh, lsuAddrPh, ifuDataPh, lsuDataPh, draining;
  logic [31:0]   expAraddr;
  logic          expArvalid, expIfuArready, expLsuArready, expIfuRvalid, expLsuRvalid, expRready;

  always_comb begin
    ifuAddrPh     = !reset && owner == 1 && !addrDone;
    lsuAddrPh     = !reset && owner == 2 && !addrDone;
    ifuDataPh     = !reset && owner == 1 && addrDone && !flush;
    lsuDataPh     = !reset && owner == 2 && addrDone;
    draining      = !reset && owner == 3;
    expAraddr     = ifuAddrPh ? ifuAraddr : (lsuAddrPh ? lsuAraddr : 32'h0);
    expArvalid    = (ifuAddrPh && ifuArvalid) || (lsuAddrPh && lsuArvalid);
    expIfuArready = ifuAddrPh && memArready;
    expLsuArready = lsuAddrPh && memArready;
    expIfuRvalid  = ifuDataPh && memRvalid;
    expLsuRvalid  = lsuDataPh && memRvalid;
    expRready     = draining || (ifuDataPh && ifuRready) || (lsuDataPh && lsuRready);
  end

  always @(negedge clock) begin
    checkOutput("mdl_mem_araddr", memAraddr, expAraddr);
    checkOutput("mdl_mem_arvalid", memArvalid, expArvalid);
    checkOutput("mdl_ifu_arready", ifuArready, expIfuArready);
    checkOutput("mdl_lsu_arready", lsuArready, expLsuArready);
    checkOutput("mdl_ifu_rvalid", ifuRvalid, expIfuRvalid);
    checkOutput("mdl_lsu_rvalid", lsuRvalid, expLsuRvalid);
    checkOutput("mdl_mem_rready", memRready, expRready);
    checkOutput("mdl_ifu_rdata", ifuRdata, memRdata);
    checkOutput("mdl_lsu_rdata", lsuRdata, memRdata);
  end

  initial begin
    // Reset with every request line active: outputs must stay silent.
    ifuArvalid = 1; lsuArvalid = 1; memArready = 1; memRvalid = 1; ifuRready = 1; lsuRready = 1;
    ifuAraddr = 32'h1234_0000; lsuAraddr = 32'h5678_0000;
    repeat (3) @(posedge clock);
    #2;
    checkOutput("rst_mem_arvalid", memArvalid, 0);
    checkOutput("rst_mem_araddr", memAraddr, 0);
    checkOutput("rst_mem_rready", memRready, 0);
    checkOutput("rst_ifu_arready", ifuArready, 0);
    checkOutput("rst_lsu_rvalid", lsuRvalid, 0);
    ifuArvalid = 0; lsuArvalid = 0; memArready = 0; memRvalid = 0; ifuRready = 0; lsuRready = 0;
    ifuAraddr = 0; lsuAraddr = 0;
    reset = 0;
    idle();

    $display("[TB] scenario 1: fetch only");
    applyStimulus(1, 32'h8000_0000, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("s1_c0_arvalid", memArvalid, 0);
    applyStimulus(1, 32'h8000_0000, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("s1_arvalid", memArvalid, 1);
    checkOutput("s1_araddr", memAraddr, 32'h8000_0000);
    applyStimulus(0, 32'h8000_0000, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("s1_wait_rvalid", ifuRvalid, 0);
    applyStimulus(0, 32'h8000_0000, 1, 0, 0, 0, 0, 1, 32'h0000_0413, 0);
    checkOutput("s1_ifu_rvalid", ifuRvalid, 1);
    checkOutput("s1_ifu_rdata", ifuRdata, 32'h0000_0413);
    checkOutput("s1_lsu_rvalid", lsuRvalid, 0);
    checkOutput("s1_mem_rready", memRready, 1);
    idle();
    checkOutput("s1_after_rvalid", ifuRvalid, 0);

    $display("[TB] scenario 2: simultaneous requests, load wins");
    applyStimulus(1, 32'h8000_0004, 1, 1, 32'h8000_1000, 1, 1, 0, 0, 0);
    checkOutput("s2_c0_arvalid", memArvalid, 0);
    applyStimulus(1, 32'h8000_0004, 1, 1, 32'h8000_1000, 1, 1, 0, 0, 1);
    checkOutput("s2_araddr", memAraddr, 32'h8000_1000);
    checkOutput("s2_lsu_arready", lsuArready, 1);
    checkOutput("s2_ifu_arready", ifuArready, 0);
    applyStimulus(1, 32'h8000_0004, 1, 0, 32'h8000_1000, 1, 1, 1, 32'h1111_2222, 0);
    checkOutput("s2_lsu_rvalid", lsuRvalid, 1);
    checkOutput("s2_lsu_rdata", lsuRdata, 32'h1111_2222);
    checkOutput("s2_ifu_rdata_shared", ifuRdata, 32'h1111_2222);
    checkOutput("s2_ifu_rvalid", ifuRvalid, 0);
    applyStimulus(1, 32'h8000_0004, 1, 0, 32'h8000_1000, 0, 1, 0, 0, 0);
    checkOutput("s2_idle_gap_arvalid", memArvalid, 0);
    applyStimulus(1, 32'h8000_0004, 1, 0, 32'h8000_1000, 0, 1, 0, 0, 0);
    checkOutput("s2_ifu_araddr", memAraddr, 32'h8000_0004);
    checkOutput("s2_ifu_arready_now", ifuArready, 1);
    applyStimulus(0, 32'h8000_0004, 1, 0, 0, 0, 0, 1, 32'h3333_4444, 0);
    checkOutput("s2_ifu_rvalid_now", ifuRvalid, 1);
    checkOutput("s2_ifu_rdata", ifuRdata, 32'h3333_4444);
    idle();

    $display("[TB] scenario 3: flush during fetch data phase");
    applyStimulus(1, 32'h8000_0008, 1, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 32'h8000_0008, 1, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("s3_arvalid", memArvalid, 1);
    applyStimulus(0, 32'h8000_0008, 1, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("s3_flush_rready", memRready, 0);
    checkOutput("s3_flush_rvalid", ifuRvalid, 0);
    applyStimulus(0, 32'h8000_0008, 1, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0);
    checkOutput("s3_drain_rvalid", ifuRvalid, 0);
    checkOutput("s3_drain_rready", memRready, 1);
    applyStimulus(1, 32'h8000_0100, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("s3_idle_arvalid", memArvalid, 0);
    checkOutput("s3_idle_rready", memRready, 0);
    applyStimulus(1, 32'h8000_0100, 1, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("s3_next_araddr", memAraddr, 32'h8000_0100);
    applyStimulus(0, 32'h8000_0100, 1, 0, 0, 0, 0, 1, 32'hCAFE_0001, 0);
    checkOutput("s3_next_rvalid", ifuRvalid, 1);
    checkOutput("s3_next_rdata", ifuRdata, 32'hCAFE_0001);
    idle();

    $display("[TB] scenario 4: flush during fetch address phase");
    applyStimulus(1, 32'h8000_0200, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h8000_0200, 1, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("s4_flush_arvalid", memArvalid, 1);
    checkOutput("s4_flush_arready", ifuArready, 0);
    applyStimulus(1, 32'h8000_0200, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("s4_hold_arvalid", memArvalid, 1);
    checkOutput("s4_hold_araddr", memAraddr, 32'h8000_0200);
    applyStimulus(1, 32'h8000_0200, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("s4_hold2_arvalid", memArvalid, 1);
    applyStimulus(1, 32'h8000_0200, 1, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("s4_ar_handshake", ifuArready, 1);
    applyStimulus(0, 32'h8000_0200, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("s4_drain_rready", memRready, 1);
    checkOutput("s4_drain_araddr", memAraddr, 0);
    applyStimulus(0, 32'h8000_0200, 1, 0, 0, 0, 0, 1, 32'hBAD0_BAD0, 0);
    checkOutput("s4_drain_rvalid", ifuRvalid, 0);
    applyStimulus(1, 32'h8000_0204, 1, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("s4_idle_arvalid", memArvalid, 0);
    applyStimulus(1, 32'h8000_0204, 1, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("s4_refetch_arvalid", memArvalid, 1);
    applyStimulus(0, 32'h8000_0204, 1, 0, 0, 0, 0, 1, 32'h0000_0005, 0);
    checkOutput("s4_refetch_rvalid", ifuRvalid, 1);
    idle();

    $display("[TB] scenario 5: load response backpressure");
    applyStimulus(0, 0, 0, 1, 32'h8000_2000, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h8000_2000, 0, 1, 0, 0, 0);
    checkOutput("s5_lsu_arready", lsuArready, 1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 32'h8000_2000, 0, 0, 1, 32'h1234_5678, (i == 1));
      checkOutput("s5_bp_rready", memRready, 0);
      checkOutput("s5_bp_rvalid", lsuRvalid, 1);
    end
    applyStimulus(0, 0, 0, 0, 32'h8000_2000, 1, 0, 1, 32'h1234_5678, 0);
    checkOutput("s5_done_rready", memRready, 1);
    checkOutput("s5_done_rdata", lsuRdata, 32'h1234_5678);
    idle();
    checkOutput("s5_after_rvalid", lsuRvalid, 0);

    $display("[TB] scenario 6: reset during load data phase");
    applyStimulus(0, 0, 0, 1, 32'h8000_3000, 1, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h8000_3000, 1, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 32'h8000_3000, 1, 0, 1, 32'h7777_8888, 0);
    checkOutput("s6_pre_rvalid", lsuRvalid, 1);
    checkOutput("s6_pre_rready", memRready, 1);
    #1 reset = 1;
    #1;
    checkOutput("s6_rst_rvalid", lsuRvalid, 0);
    checkOutput("s6_rst_rready", memRready, 0);
    checkOutput("s6_rst_arvalid", memArvalid, 0);
    checkOutput("s6_rst_arready", lsuArready, 0);
    idle();
    idle();
    reset = 0;
    applyStimulus(1, 32'h8000_0300, 1, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("s6_idle_arvalid", memArvalid, 0);
    applyStimulus(1, 32'h8000_0300, 1, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("s6_grant_araddr", memAraddr, 32'h8000_0300);
    checkOutput("s6_grant_arvalid", memArvalid, 1);
    applyStimulus(0, 32'h8000_0300, 1, 0, 0, 0, 0, 1, 32'hABCD_0300, 0);
    checkOutput("s6_ifu_rvalid", ifuRvalid, 1);
    idle();
    idle();

    @(posedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
